rename_frat: RTL and testbench
==============================

Name: rename_frat

Overview:
- Register-rename stage between the Rename Queue (RQ) and the Issue Queue (IQ).
- Takes one decoded instruction per cycle from RQ (architectural rs/rt/rd) and returns physical source tags, a newly allocated physical destination and the displaced old destination tag.
- Holds the Front-end RAT (FRAT), a Retirement RAT (RRAT) updated at commit, and a circular free list.
- Flush restores the FRAT and the free list to the committed state.

Parameters:
- ARCH_REGS, 32, architectural register count.
- PHYS_REGS, 64, physical register count.
- PTAG_W, 6, physical tag width, log2(PHYS_REGS).
- FL_DEPTH, 32, free-list depth, PHYS_REGS-ARCH_REGS.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- valid_IN  in  1  RQ presents an instruction.
- Instr_PC_IN  in  32  instruction PC.
- rs_IN  in  5  architectural source 1.
- rt_IN  in  5  architectural source 2.
- rd_IN  in  5  architectural destination.
- writesRd_IN  in  1  instruction writes rd.
- STALL_IN_IQ  in  1  IQ cannot accept this cycle.
- commit_valid_IN  in  1  ROB retires a dest-writing instruction.
- commit_rd_IN  in  5  retiring architectural destination.
- commit_prd_IN  in  PTAG_W  retiring physical destination.
- commit_old_prd_IN  in  PTAG_W  tag freed by the retirement.
- flush_IN  in  1  mispredict/exception flush.
- STALL_OUT_RQ  out  1  RQ must hold its instruction.
- valid_OUT  out  1  renamed instruction valid to IQ.
- Instr_PC_OUT  out  32  registered PC.
- prs_OUT  out  PTAG_W  physical tag of rs.
- prt_OUT  out  PTAG_W  physical tag of rt.
- prd_OUT  out  PTAG_W  newly allocated tag, 0 if no dest.
- old_prd_OUT  out  PTAG_W  previous mapping of rd, 0 if no dest.
- hasDest_OUT  out  1  prd_OUT valid.

Behaviour:
- Reset (async): FRAT[i]=RRAT[i]=i; free-list entry k=32+k; head=tail=retire_head=0; count=32. valid_OUT=0, hasDest_OUT=0, all tag outputs 0, Instr_PC_OUT=0.
- needs_dest = writesRd_IN && rd_IN!=0. Register r0 is never renamed and always maps to phys 0.
- STALL_OUT_RQ is combinational: flush_IN || (valid_OUT && STALL_IN_IQ) || (count==0). It does not depend on valid_IN, and there is no commit bypass, so the path stays short.
- Accept = valid_IN && !STALL_OUT_RQ.
- On accept, the output register loads at the next edge (1-cycle latency):
  - prs/prt come from the FRAT before this instruction's rd update, so rs==rd reads the old mapping.
  - If needs_dest: prd=freelist[head], old_prd=FRAT[rd]; FRAT[rd]<=prd; head++ (mod 32); count--.
- Output hold: while valid_OUT && STALL_IN_IQ, all outputs keep their values.
- Output clear: if there is no accept and IQ is not stalling, valid_OUT<=0 and the other outputs are don't-care.
- Commit: if commit_valid_IN, then RRAT[commit_rd]<=commit_prd; freelist[tail]<=commit_old_prd; tail++; retire_head++; count++.
  - Commit and allocate in the same cycle: both happen, net count unchanged.
  - count never exceeds FL_DEPTH. Exceeding it is an illegal-stimulus assertion.
- Flush (priority over accept):
  - FRAT<=RRAT, with a same-cycle commit's RRAT write included (copied value shows the commit).
  - head<=retire_head (post-commit value).
  - count<=FL_DEPTH.
  - valid_OUT<=0.
  - No rename happens in the flush cycle.
- Pointer wrap: all pointers are 5-bit, modulo 32, and wrap silently.
- Full/empty: count==0 stalls every instruction, even one with no dest (conservative). count==32 means every non-committed tag is free.

Test Plan:
- Reset then rename add r3,r1,r2 → next cycle valid_OUT=1, prs=1, prt=2, prd=32, old_prd=3. A following instr reading r3 gets prs=32.
- Rename r5←r5+r5 twice back-to-back → first prs=5, prd=32, old=5. Second prs=prt=32, prd=33, old=32.
- 32 dest-writing renames with no commits → count=0, STALL_OUT_RQ=1, 33rd held. Commit old_prd=7 → next cycle 33rd renamed with prd=7.
- Write to r0 (writesRd=1, rd=0) → hasDest_OUT=0, prd=0, count unchanged.
- STALL_IN_IQ high 3 cycles with valid_OUT=1 → outputs stable, STALL_OUT_RQ=1, FRAT/head unchanged.
- Rename r4→32, r4→33, commit first (rd=4, prd=32, old=4) with flush_IN in the same cycle → FRAT[4]=32, head=retire_head=1, count=32. Next rename of r4 gets old_prd=32, prd=33.

Source files
------------

// File: rtl/rename_frat.sv
// Register rename: FRAT lookup, free-list allocation, RRAT update at commit, flush to committed state.
// One-cycle rename latency; output register holds while IQ stalls, RQ is stalled on flush/IQ stall/empty free list.
module rename_frat #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int PTAG_W    = 6,
    parameter int FL_DEPTH  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              valid_IN,
    input  logic [31:0]       Instr_PC_IN,
    input  logic [4:0]        rs_IN,
    input  logic [4:0]        rt_IN,
    input  logic [4:0]        rd_IN,
    input  logic              writesRd_IN,
    input  logic              STALL_IN_IQ,
    input  logic              commit_valid_IN,
    input  logic [4:0]        commit_rd_IN,
    input  logic [PTAG_W-1:0] commit_prd_IN,
    input  logic [PTAG_W-1:0] commit_old_prd_IN,
    input  logic              flush_IN,
    output logic              STALL_OUT_RQ,
    output logic              valid_OUT,
    output logic [31:0]       Instr_PC_OUT,
    output logic [PTAG_W-1:0] prs_OUT,
    output logic [PTAG_W-1:0] prt_OUT,
    output logic [PTAG_W-1:0] prd_OUT,
    output logic [PTAG_W-1:0] old_prd_OUT,
    output logic              hasDest_OUT
);
    localparam int PTR_W = $clog2(PHYS_REGS - ARCH_REGS);
    localparam int CNT_W = PTR_W + 1;

    logic [PTAG_W-1:0] frat      [ARCH_REGS];
    logic [PTAG_W-1:0] rrat      [ARCH_REGS];
    logic [PTAG_W-1:0] free_list [FL_DEPTH];
    logic [PTR_W-1:0]  head, tail, retire_head;
    logic [CNT_W-1:0]  count;

    logic needs_dest, accept, alloc, out_hold;

    assign needs_dest   = writesRd_IN && (rd_IN != 5'd0);
    assign out_hold     = valid_OUT && STALL_IN_IQ;
    // No commit bypass on the empty check keeps this a short path to RQ.
    assign STALL_OUT_RQ = flush_IN || out_hold || (count == '0);
    assign accept       = valid_IN && !STALL_OUT_RQ;
    assign alloc        = accept && needs_dest;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                frat[i] <= PTAG_W'(i);
                rrat[i] <= PTAG_W'(i);
            end
            for (int k = 0; k < FL_DEPTH; k++)
                free_list[k] <= PTAG_W'(ARCH_REGS + k);
            head        <= '0;
            tail        <= '0;
            retire_head <= '0;
            count       <= CNT_W'(FL_DEPTH);
        end else begin
            if (commit_valid_IN) begin
                rrat[commit_rd_IN] <= commit_prd_IN;
                free_list[tail]    <= commit_old_prd_IN;
                tail               <= tail + 1'b1;
                retire_head        <= retire_head + 1'b1;
            end
            if (flush_IN) begin
                // The restored map must already reflect a commit retiring this same cycle.
                for (int i = 0; i < ARCH_REGS; i++)
                    frat[i] <= (commit_valid_IN && commit_rd_IN == 5'(i)) ? commit_prd_IN : rrat[i];
                head  <= retire_head + PTR_W'(commit_valid_IN);
                count <= CNT_W'(FL_DEPTH);
            end else begin
                if (alloc) begin
                    frat[rd_IN] <= free_list[head];
                    head        <= head + 1'b1;
                end
                count <= count + CNT_W'(commit_valid_IN) - CNT_W'(alloc);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_OUT    <= 1'b0;
            Instr_PC_OUT <= '0;
            prs_OUT      <= '0;
            prt_OUT      <= '0;
            prd_OUT      <= '0;
            old_prd_OUT  <= '0;
            hasDest_OUT  <= 1'b0;
        end else if (flush_IN) begin
            valid_OUT <= 1'b0;
        end else if (out_hold) begin
            valid_OUT <= 1'b1;
        end else if (accept) begin
            valid_OUT    <= 1'b1;
            Instr_PC_OUT <= Instr_PC_IN;
            prs_OUT      <= frat[rs_IN];
            prt_OUT      <= frat[rt_IN];
            prd_OUT      <= needs_dest ? free_list[head] : '0;
            old_prd_OUT  <= needs_dest ? frat[rd_IN] : '0;
            hasDest_OUT  <= needs_dest;
        end else begin
            valid_OUT <= 1'b0;
        end
    end

    // A commit that would push the free list past its depth is illegal stimulus.
    always_ff @(posedge CLK) begin
        if (!RESET && !flush_IN)
            assert (!(commit_valid_IN && !alloc && count == CNT_W'(FL_DEPTH)));
    end
endmodule

// File: tb/tb_rename_frat.sv
// Directed bench for rename_frat with a scoreboard of expected renamed outputs.
module tb_rename_frat;
    localparam int PTAG_W = 6;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              valid_IN;
    logic [31:0]       Instr_PC_IN;
    logic [4:0]        rs_IN, rt_IN, rd_IN;
    logic              writesRd_IN;
    logic              STALL_IN_IQ;
    logic              commit_valid_IN;
    logic [4:0]        commit_rd_IN;
    logic [PTAG_W-1:0] commit_prd_IN, commit_old_prd_IN;
    logic              flush_IN;
    logic              STALL_OUT_RQ;
    logic              valid_OUT;
    logic [31:0]       Instr_PC_OUT;
    logic [PTAG_W-1:0] prs_OUT, prt_OUT, prd_OUT, old_prd_OUT;
    logic              hasDest_OUT;

    rename_frat dut (
        .CLK(CLK), .RESET(RESET), .valid_IN(valid_IN), .Instr_PC_IN(Instr_PC_IN),
        .rs_IN(rs_IN), .rt_IN(rt_IN), .rd_IN(rd_IN), .writesRd_IN(writesRd_IN),
        .STALL_IN_IQ(STALL_IN_IQ), .commit_valid_IN(commit_valid_IN),
        .commit_rd_IN(commit_rd_IN), .commit_prd_IN(commit_prd_IN),
        .commit_old_prd_IN(commit_old_prd_IN), .flush_IN(flush_IN),
        .STALL_OUT_RQ(STALL_OUT_RQ), .valid_OUT(valid_OUT), .Instr_PC_OUT(Instr_PC_OUT),
        .prs_OUT(prs_OUT), .prt_OUT(prt_OUT), .prd_OUT(prd_OUT),
        .old_prd_OUT(old_prd_OUT), .hasDest_OUT(hasDest_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0]       pc;
        logic [PTAG_W-1:0] prs, prt, prd, old;
        logic              hd;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic send(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic wr,
                        input logic [PTAG_W-1:0] eprs, input logic [PTAG_W-1:0] eprt,
                        input logic [PTAG_W-1:0] eprd, input logic [PTAG_W-1:0] eold);
        exp_t e;
        valid_IN = 1'b1; Instr_PC_IN = pc; rs_IN = rs; rt_IN = rt; rd_IN = rd; writesRd_IN = wr;
        e.pc = pc; e.prs = eprs; e.prt = eprt; e.prd = eprd; e.old = eold;
        e.hd = wr && (rd != 5'd0);
        sb.push_back(e);
    endtask

    // One clock; if the instruction on the RQ side was accepted, its result is checked after the edge.
    task automatic step();
        bit   acc;
        exp_t e;
        #2;
        acc = valid_IN && !STALL_OUT_RQ;
        @(posedge CLK);
        #1;
        if (acc) begin
            valid_IN = 1'b0;
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("valid", valid_OUT, 1);
                chk("pc", Instr_PC_OUT, e.pc);
                chk("prs", prs_OUT, e.prs);
                chk("prt", prt_OUT, e.prt);
                chk("prd", prd_OUT, e.prd);
                chk("old_prd", old_prd_OUT, e.old);
                chk("hasDest", hasDest_OUT, e.hd);
                last = e;
            end
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        valid_IN = 0; Instr_PC_IN = 0; rs_IN = 0; rt_IN = 0; rd_IN = 0; writesRd_IN = 0;
        STALL_IN_IQ = 0; commit_valid_IN = 0; commit_rd_IN = 0; commit_prd_IN = 0;
        commit_old_prd_IN = 0; flush_IN = 0;
        sb.delete();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    logic [PTAG_W-1:0] mfrat [32];
    logic [4:0]        rdk;

    initial begin
        do_reset();
        chk("rst_valid", valid_OUT, 0);
        chk("rst_hasDest", hasDest_OUT, 0);
        chk("rst_pc", Instr_PC_OUT, 0);
        chk("rst_tags", {prs_OUT, prt_OUT, prd_OUT, old_prd_OUT}, 0);
        chk("rst_stall", STALL_OUT_RQ, 0);

        // add r3,r1,r2 then a reader of r3
        send(32'h100, 1, 2, 3, 1, 1, 2, 32, 3); step();
        send(32'h104, 3, 0, 0, 0, 32, 0, 0, 0); step();
        step();
        chk("t1_drain", valid_OUT, 0);

        // r5 <- r5 + r5 twice back to back
        do_reset();
        send(32'h200, 5, 5, 5, 1, 5, 5, 32, 5); step();
        send(32'h204, 5, 5, 5, 1, 32, 32, 33, 32); step();
        step();

        // exhaust the free list, then a commit releases tag 7
        do_reset();
        for (int i = 0; i < 32; i++) mfrat[i] = PTAG_W'(i);
        for (int k = 0; k < 32; k++) begin
            rdk = 5'(k % 31 + 1);
            send(32'h1000 + 32'(4 * k), 0, 0, rdk, 1, 0, 0, PTAG_W'(32 + k), mfrat[rdk]);
            mfrat[rdk] = PTAG_W'(32 + k);
            step();
        end
        send(32'h2000, 3, 0, 2, 1, mfrat[3], 0, 7, mfrat[2]);
        step();
        chk("empty_stall", STALL_OUT_RQ, 1);
        chk("empty_no_out", valid_OUT, 0);
        step();
        chk("empty_stall2", STALL_OUT_RQ, 1);
        commit_valid_IN = 1; commit_rd_IN = 1; commit_prd_IN = 32; commit_old_prd_IN = 7;
        #1;
        chk("no_commit_bypass", STALL_OUT_RQ, 1);
        step();
        commit_valid_IN = 0;
        chk("after_commit_stall", STALL_OUT_RQ, 0);
        step();
        chk("empty_again", STALL_OUT_RQ, 1);

        // write to r0 is not renamed and consumes nothing
        do_reset();
        send(32'h300, 1, 2, 0, 1, 1, 2, 0, 0); step();
        send(32'h304, 0, 0, 6, 1, 0, 0, 32, 6); step();
        step();

        // IQ stall holds the output register and freezes renaming
        do_reset();
        send(32'h400, 1, 2, 7, 1, 1, 2, 32, 7); step();
        STALL_IN_IQ = 1;
        send(32'h404, 7, 0, 8, 1, 32, 0, 33, 8);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("hold_valid", valid_OUT, 1);
            chk("hold_pc", Instr_PC_OUT, last.pc);
            chk("hold_prd", prd_OUT, last.prd);
            chk("hold_old", old_prd_OUT, last.old);
            chk("hold_stall", STALL_OUT_RQ, 1);
        end
        STALL_IN_IQ = 0;
        step();
        step();

        // flush with a same-cycle commit restores the committed map
        do_reset();
        send(32'h500, 0, 0, 4, 1, 0, 0, 32, 4); step();
        send(32'h504, 0, 0, 4, 1, 0, 0, 33, 32); step();
        commit_valid_IN = 1; commit_rd_IN = 4; commit_prd_IN = 32; commit_old_prd_IN = 4;
        flush_IN = 1;
        #1;
        chk("flush_stall", STALL_OUT_RQ, 1);
        step();
        commit_valid_IN = 0; flush_IN = 0;
        chk("flush_valid", valid_OUT, 0);
        send(32'h508, 4, 0, 4, 1, 32, 0, 33, 32); step();
        step();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
